// File: rtl/wb_burst_resp.sv
// Wishbone burst responder: terminates single/burst transfers onto a 1-cycle-latency local memory.
// Define WB_BURST_ERR_EN to answer out-of-window or overrunning requests with err beats instead of wrapping.
module wb_burst_resp #(
    parameter int          AW        = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic [31:0]   wbs_dat_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [9:0]    wbs_bl_i,
    input  logic          wbs_bry_i,
    input  logic          wbs_we_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    output logic [31:0]   wbs_dat_o,
    output logic          wbs_ack_o,
    output logic          wbs_lack_o,
    output logic          wbs_err_o,
    output logic          mem_cs_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [3:0]    mem_wmask_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, WR, RD, GAP} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [9:0]    blen_q, blen_d, beat_cnt_q, beat_cnt_d, iss_cnt_q, iss_cnt_d;
    logic          err_mode_q, err_mode_d;
    logic          rd_pend_q, rd_pend_d, rd_vld_q, rd_vld_d, skid_vld_q, skid_vld_d;
    logic [31:0]   rd_data_q, rd_data_d, skid_q, skid_d;

    logic          req, in_burst, beat, last_beat;
    logic          wr_beat, rd_ack, rd_issue, err_beat, lack;
    logic [1:0]    occ;
    logic [9:0]    bl_eff;
    logic          req_err;

`ifdef WB_BURST_ERR_EN
    localparam logic [AW+10:0] WIN_END = {{10{1'b0}}, 1'b1, {AW{1'b0}}};
    logic [AW+10:0] end_addr;
    logic           unused_bits;
    assign end_addr    = {11'd0, wbs_adr_i[AW+1:2]} + {{(AW+1){1'b0}}, bl_eff};
    assign req_err     = (wbs_adr_i[31:AW+2] != BASE_ADDR[31:AW+2]) || (end_addr > WIN_END);
    assign unused_bits = ^{wbs_adr_i[1:0], BASE_ADDR[AW+1:0]};
`else
    logic unused_bits;
    assign req_err     = 1'b0;
    assign unused_bits = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0], BASE_ADDR};
`endif

    assign req       = wbs_cyc_i & wbs_stb_i;
    assign bl_eff    = (wbs_bl_i == 10'd0) ? 10'd1 : wbs_bl_i;
    assign in_burst  = (state_q == WR) || (state_q == RD);
    assign beat      = in_burst & wbs_cyc_i & wbs_stb_i & wbs_bry_i;
    assign last_beat = (beat_cnt_q == blen_q - 10'd1);
    assign wr_beat   = beat & (state_q == WR) & ~err_mode_q;
    assign rd_ack    = beat & (state_q == RD) & ~err_mode_q & rd_vld_q;
    assign err_beat  = beat & err_mode_q;
    assign lack      = (wr_beat | rd_ack | err_beat) & last_beat;

    // A read is only issued when its data is guaranteed a landing slot (head or skid) the
    // following cycle, so reads stream at 1 beat/cycle and back-pressure never drops data.
    assign occ      = {1'b0, rd_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_pend_q};
    assign rd_issue = (state_q == RD) & ~err_mode_q & wbs_cyc_i & (iss_cnt_q < blen_q)
                    & ((occ - {1'b0, rd_ack}) < 2'd2);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            blen_q     <= '0;
            beat_cnt_q <= '0;
            iss_cnt_q  <= '0;
            err_mode_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
            skid_vld_q <= 1'b0;
            rd_data_q  <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            blen_q     <= blen_d;
            beat_cnt_q <= beat_cnt_d;
            iss_cnt_q  <= iss_cnt_d;
            err_mode_q <= err_mode_d;
            rd_pend_q  <= rd_pend_d;
            rd_vld_q   <= rd_vld_d;
            skid_vld_q <= skid_vld_d;
            rd_data_q  <= rd_data_d;
            skid_q     <= skid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        blen_d     = blen_q;
        beat_cnt_d = beat_cnt_q;
        iss_cnt_d  = iss_cnt_q;
        err_mode_d = err_mode_q;
        rd_pend_d  = rd_issue;
        rd_vld_d   = rd_vld_q;
        skid_vld_d = skid_vld_q;
        rd_data_d  = rd_data_q;
        skid_d     = skid_q;
        case (state_q)
            IDLE: begin
                beat_cnt_d = '0;
                iss_cnt_d  = '0;
                rd_vld_d   = 1'b0;
                skid_vld_d = 1'b0;
                if (req) begin
                    addr_d     = wbs_adr_i[AW+1:2];
                    blen_d     = bl_eff;
                    err_mode_d = req_err;
                    state_d    = wbs_we_i ? WR : RD;
`ifdef WB_BURST_ERR_EN
                    if (req_err) rd_data_d = '0;
`endif
                end
            end
            WR, RD: begin
                if (!wbs_cyc_i) begin
                    state_d    = IDLE;
                    rd_vld_d   = 1'b0;
                    skid_vld_d = 1'b0;
                end else begin
                    if (wr_beat | rd_ack | err_beat) beat_cnt_d = beat_cnt_q + 10'd1;
                    if (wr_beat | rd_issue) addr_d = addr_q + AW'(1);
                    if (rd_issue) iss_cnt_d = iss_cnt_q + 10'd1;
                    // Head register feeds dat_o; it only changes when empty or being consumed.
                    if (state_q == RD) begin
                        if (!rd_vld_q || rd_ack) begin
                            if (skid_vld_q) begin
                                rd_data_d  = skid_q;
                                rd_vld_d   = 1'b1;
                                skid_vld_d = rd_pend_q;
                                if (rd_pend_q) skid_d = mem_rdata_i;
                            end else if (rd_pend_q) begin
                                rd_data_d = mem_rdata_i;
                                rd_vld_d  = 1'b1;
                            end else begin
                                rd_vld_d = 1'b0;
                            end
                        end else if (rd_pend_q) begin
                            skid_d     = mem_rdata_i;
                            skid_vld_d = 1'b1;
                        end
                    end
                    if (lack) state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o   = wr_beat | rd_ack;
        wbs_err_o   = err_beat;
        wbs_lack_o  = lack;
        wbs_dat_o   = rd_data_q;
        mem_cs_o    = wr_beat | rd_issue;
        mem_we_o    = wr_beat;
        mem_addr_o  = (wr_beat | rd_issue) ? addr_q : '0;
        mem_wmask_o = wr_beat ? wbs_sel_i : 4'h0;
        mem_wdata_o = wr_beat ? wbs_dat_i : 32'h0;
    end
endmodule

// File: tb/tb_wb_burst_resp.sv
// Directed self-checking bench for wb_burst_resp with a 256-word synchronous memory model.
// Each bench cycle starts at the falling clock edge: inputs are driven, outputs sampled 1 time unit later.
module tb_wb_burst_resp;
    localparam int AW = 8;

    logic          clk_i = 1'b0;
    logic          rst_n;
    logic [31:0]   wbs_dat_i, wbs_adr_i;
    logic [3:0]    wbs_sel_i;
    logic [9:0]    wbs_bl_i;
    logic          wbs_bry_i, wbs_we_i, wbs_cyc_i, wbs_stb_i;
    logic [31:0]   wbs_dat_o;
    logic          wbs_ack_o, wbs_lack_o, wbs_err_o;
    logic          mem_cs_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [3:0]    mem_wmask_o;
    logic [31:0]   mem_wdata_o, mem_rdata_i;

    wb_burst_resp #(.AW(AW), .BASE_ADDR(32'h0000_0000)) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i), .wbs_sel_i(wbs_sel_i), .wbs_bl_i(wbs_bl_i),
        .wbs_bry_i(wbs_bry_i), .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_lack_o(wbs_lack_o), .wbs_err_o(wbs_err_o),
        .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wmask_o(mem_wmask_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory preloaded with mem[i] = i so read data is predictable.
    logic [31:0] mem [0:255];
    logic [31:0] wmask_bits;
    assign wmask_bits = {{8{mem_wmask_o[3]}}, {8{mem_wmask_o[2]}}, {8{mem_wmask_o[1]}}, {8{mem_wmask_o[0]}}};

    initial for (int i = 0; i < 256; i++) mem[i] <= 32'(i);

    always @(posedge clk_i) begin
        if (mem_cs_o && mem_we_o)
            mem[mem_addr_o] <= (mem[mem_addr_o] & ~wmask_bits) | (mem_wdata_o & wmask_bits);
        if (mem_cs_o && !mem_we_o)
            mem_rdata_i <= mem[mem_addr_o];
    end

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] got_data [0:15];
    logic [AW-1:0] got_addr [0:15];
    logic [3:0]  got_mask [0:15];
    int          n_ack, n_err, n_lack, lack_idx, first_ack_cyc, abort_cs, lack_wo_ack;
    int          stall_bad, gap_bad, cs_cnt;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cyc, input logic stb, input logic we, input logic bry,
                                 input logic [31:0] adr, input logic [9:0] bl,
                                 input logic [3:0] sel, input logic [31:0] dat);
        wbs_cyc_i = cyc;
        wbs_stb_i = stb;
        wbs_we_i  = we;
        wbs_bry_i = bry;
        wbs_adr_i = adr;
        wbs_bl_i  = bl;
        wbs_sel_i = sel;
        wbs_dat_i = dat;
    endtask

    // Runs one transfer starting in an IDLE cycle; bry for burst cycle c is bry_pat[(c-1)%4].
    // abort_after > 0 drops cyc once that many acks were seen.
    task automatic runBurst(input string tag, input logic we, input logic [31:0] adr, input logic [9:0] bl,
                            input logic [3:0] bry_pat, input logic [31:0] wbase, input logic [3:0] sel,
                            input int abort_after);
        bit          done;
        bit          aborted;
        int          c;
        logic [31:0] prev_dat;
        logic        prev_bry;
        done = 0; aborted = 0; c = 0; prev_dat = '0; prev_bry = 1'b1;
        n_ack = 0; n_err = 0; n_lack = 0; lack_idx = -1; first_ack_cyc = -1;
        abort_cs = 0; lack_wo_ack = 0; stall_bad = 0; gap_bad = 0; cs_cnt = 0;
        applyStimulus(1'b1, 1'b1, we, 1'b1, adr, bl, sel, wbase);
        #1;
        if (wbs_ack_o || wbs_err_o || mem_cs_o) cs_cnt++;
        @(negedge clk_i);
        while (!done && c < 64) begin
            c++;
            applyStimulus(1'b1, 1'b1, we, bry_pat[(c-1)%4], ~adr, bl + 10'd3, sel, wbase + 32'(n_ack));
            #1;
            if (mem_cs_o) cs_cnt++;
            if (wbs_lack_o && !(wbs_ack_o || wbs_err_o)) lack_wo_ack++;
            if (wbs_err_o) begin
                n_err++;
                if (wbs_lack_o) begin n_lack++; lack_idx = n_err - 1; done = 1; end
            end
            if (wbs_ack_o) begin
                if (first_ack_cyc < 0) first_ack_cyc = c;
                if (n_ack < 16) begin
                    got_data[n_ack] = we ? mem_wdata_o : wbs_dat_o;
                    got_addr[n_ack] = mem_addr_o;
                    got_mask[n_ack] = mem_wmask_o;
                end
                if (!we && !prev_bry && c > 1 && wbs_dat_o !== prev_dat) stall_bad++;
                if (wbs_lack_o) begin n_lack++; lack_idx = n_ack; done = 1; end
                n_ack++;
            end
            prev_dat = wbs_dat_o;
            prev_bry = wbs_bry_i;
            @(negedge clk_i);
            if (!done && abort_after > 0 && n_ack == abort_after) begin
                done = 1;
                aborted = 1;
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 10'd0, 4'h0, 32'h0);
                for (int k = 0; k < 5; k++) begin
                    #1;
                    if (mem_cs_o || wbs_ack_o || wbs_lack_o) abort_cs++;
                    @(negedge clk_i);
                end
            end
        end
        checkOutput({tag, "_terminated"}, 32'(done), 32'd1);
        if (done && !aborted) begin
            // GAP cycle: keep strobing to show it is ignored.
            applyStimulus(1'b1, 1'b1, we, 1'b1, adr, bl, sel, wbase);
            #1;
            if (wbs_ack_o || wbs_err_o || wbs_lack_o || mem_cs_o) gap_bad++;
            @(negedge clk_i);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 10'd0, 4'h0, 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 10'd1, 4'hF, 32'hFFFF_FFFF);
        @(negedge clk_i);
        #1;
        checkOutput("rst_ack_lack_err", {29'd0, wbs_ack_o, wbs_lack_o, wbs_err_o}, 32'd0);
        checkOutput("rst_mem_ctl", {24'd0, mem_cs_o, mem_we_o, 2'b00, mem_wmask_o}, 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata_o, 32'd0);
        checkOutput("rst_dat_o", wbs_dat_o, 32'd0);
        @(negedge clk_i);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 10'd0, 4'h0, 32'h0);
        @(negedge clk_i);

        $display("[TB] read burst bl=8 from word 0 with bry 1,0,0,1");
        runBurst("burst_rd", 1'b0, 32'h0, 10'd8, 4'b1001, 32'h0, 4'hF, 0);
        checkOutput("burst_rd_acks", 32'(n_ack), 32'd8);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("burst_rd_data%0d", i), got_data[i], 32'(i));
        checkOutput("burst_rd_lack_idx", 32'(lack_idx), 32'd7);
        checkOutput("burst_rd_lack_cnt", 32'(n_lack), 32'd1);
        checkOutput("burst_rd_first_ack", 32'(first_ack_cyc), 32'd4);
        checkOutput("burst_rd_stall_stable", 32'(stall_bad), 32'd0);
        checkOutput("burst_rd_lack_wo_ack", 32'(lack_wo_ack), 32'd0);
        checkOutput("burst_rd_gap_quiet", 32'(gap_bad), 32'd0);

        $display("[TB] single write / read at 0x10");
        runBurst("wr1", 1'b1, 32'h10, 10'd1, 4'b1111, 32'hDEAD_BEEF, 4'hF, 0);
        checkOutput("wr1_acks", 32'(n_ack), 32'd1);
        checkOutput("wr1_first_ack", 32'(first_ack_cyc), 32'd1);
        checkOutput("wr1_lack_idx", 32'(lack_idx), 32'd0);
        checkOutput("wr1_addr", 32'(got_addr[0]), 32'd4);
        checkOutput("wr1_mask", 32'(got_mask[0]), 32'hF);
        checkOutput("wr1_wdata", got_data[0], 32'hDEAD_BEEF);
        runBurst("rd1", 1'b0, 32'h10, 10'd1, 4'b1111, 32'h0, 4'hF, 0);
        checkOutput("rd1_acks", 32'(n_ack), 32'd1);
        checkOutput("rd1_first_ack", 32'(first_ack_cyc), 32'd3);
        checkOutput("rd1_lack_idx", 32'(lack_idx), 32'd0);
        checkOutput("rd1_data", got_data[0], 32'hDEAD_BEEF);

        $display("[TB] byte mask with bl=0");
        runBurst("mask_wr", 1'b1, 32'h0, 10'd0, 4'b1111, 32'hAABB_CCDD, 4'b0101, 0);
        checkOutput("mask_wr_acks", 32'(n_ack), 32'd1);
        checkOutput("mask_wr_lack_idx", 32'(lack_idx), 32'd0);
        checkOutput("mask_wr_mask", 32'(got_mask[0]), 32'h5);
        runBurst("mask_rd", 1'b0, 32'h0, 10'd1, 4'b1111, 32'h0, 4'hF, 0);
        checkOutput("mask_rd_data", got_data[0], 32'h00BB_00DD);

`ifndef WB_BURST_ERR_EN
        $display("[TB] write burst wrapping past the window top");
        runBurst("wrap_wr", 1'b1, 32'h0000_03F8, 10'd4, 4'b1111, 32'h5000_0000, 4'hF, 0);
        checkOutput("wrap_wr_acks", 32'(n_ack), 32'd4);
        checkOutput("wrap_wr_addr0", 32'(got_addr[0]), 32'd254);
        checkOutput("wrap_wr_addr1", 32'(got_addr[1]), 32'd255);
        checkOutput("wrap_wr_addr2", 32'(got_addr[2]), 32'd0);
        checkOutput("wrap_wr_addr3", 32'(got_addr[3]), 32'd1);
        checkOutput("wrap_wr_lack_idx", 32'(lack_idx), 32'd3);
`endif

        $display("[TB] read burst aborted after 3 acks");
        runBurst("abort_rd", 1'b0, 32'h20, 10'd8, 4'b1111, 32'h0, 4'hF, 3);
        checkOutput("abort_rd_acks", 32'(n_ack), 32'd3);
        checkOutput("abort_rd_data2", got_data[2], 32'd10);
        checkOutput("abort_rd_no_lack", 32'(n_lack), 32'd0);
        checkOutput("abort_rd_quiet", 32'(abort_cs), 32'd0);
        runBurst("post_abort_rd", 1'b0, 32'h0000_03FC, 10'd1, 4'b1111, 32'h0, 4'hF, 0);
        checkOutput("post_abort_first_ack", 32'(first_ack_cyc), 32'd3);
`ifndef WB_BURST_ERR_EN
        checkOutput("post_abort_data", got_data[0], 32'h5000_0001);
`else
        checkOutput("post_abort_data", got_data[0], 32'd255);
`endif

`ifdef WB_BURST_ERR_EN
        $display("[TB] read outside the window");
        runBurst("err_rd", 1'b0, 32'h0000_0400, 10'd2, 4'b1111, 32'h0, 4'hF, 0);
        checkOutput("err_rd_errs", 32'(n_err), 32'd2);
        checkOutput("err_rd_acks", 32'(n_ack), 32'd0);
        checkOutput("err_rd_lack_idx", 32'(lack_idx), 32'd1);
        checkOutput("err_rd_no_cs", 32'(cs_cnt), 32'd0);
        checkOutput("err_rd_dat_o", wbs_dat_o, 32'd0);
`endif

        $display("[TB] reset during a write burst");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0190, 10'd8, 4'hF, 32'h7700_0000);
        for (int k = 0; k < 3; k++) @(negedge clk_i);
        #1;
        checkOutput("rstmid_ack_before", 32'(wbs_ack_o), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_ack_lack_err", {29'd0, wbs_ack_o, wbs_lack_o, wbs_err_o}, 32'd0);
        checkOutput("rstmid_mem_ctl", {26'd0, mem_cs_o, mem_we_o, mem_wmask_o}, 32'd0);
        checkOutput("rstmid_mem_wdata", mem_wdata_o, 32'd0);
        checkOutput("rstmid_dat_o", wbs_dat_o, 32'd0);
        @(negedge clk_i);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 10'd0, 4'h0, 32'h0);
        @(negedge clk_i);
        runBurst("after_rst_wr", 1'b1, 32'h0000_01E0, 10'd2, 4'b1111, 32'h1234_0000, 4'hF, 0);
        checkOutput("after_rst_wr_acks", 32'(n_ack), 32'd2);
        checkOutput("after_rst_wr_first_ack", 32'(first_ack_cyc), 32'd1);
        checkOutput("after_rst_wr_addr1", 32'(got_addr[1]), 32'd121);
        runBurst("after_rst_rd", 1'b0, 32'h0000_01E0, 10'd2, 4'b1111, 32'h0, 4'hF, 0);
        checkOutput("after_rst_rd_data0", got_data[0], 32'h1234_0000);
        checkOutput("after_rst_rd_data1", got_data[1], 32'h1234_0001);
        checkOutput("after_rst_rd_lack_idx", 32'(lack_idx), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
